// File: rtl/seven_seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver_if
//   Bundles the datapath-facing and display-facing signals of the
//   seven-segment scan driver.
//
//   Handshake: load is a single-cycle strobe with no ready/back-pressure.
//   The driver always accepts value_in in any cycle where load=1. The value
//   waits (pending=1) until the next frame boundary and is then shown. A
//   later load before that boundary replaces the waiting value.
//
//   Signals
//     value_in   master->slave  4*N_DIGITS packed nibbles, [3:0] = digit 0
//     load       master->slave  capture value_in this cycle
//     blank_in   master->slave  force whole display dark
//     segment    slave->master  {g,f,e,d,c,b,a}, registered
//     digit_sel  slave->master  one-hot digit enable, registered
//     frame_tick slave->master  1-cycle pulse at each frame boundary
//     pending    slave->master  captured value waiting for frame boundary
//     dbg_idx    slave->master  current scan index (observability)
// ---------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value_in;
  logic                  load;
  logic                  blank_in;
  logic [6:0]            segment;
  logic [N_DIGITS-1:0]   digit_sel;
  logic                  frame_tick;
  logic                  pending;
  logic [2:0]            dbg_idx;

  modport master (
    output value_in, load, blank_in,
    input  segment, digit_sel, frame_tick, pending, dbg_idx
  );

  modport slave (
    input  value_in, load, blank_in,
    output segment, digit_sel, frame_tick, pending, dbg_idx
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed driver for an N-digit seven-segment display. A loaded
//   hex value is held in pend_reg until the end of the current frame, so a
//   frame never mixes digits of an old and a new value. One digit is enabled
//   per PRESCALE clock cycles and its nibble is decoded to a hex glyph.
//
//   Parameters
//     N_DIGITS       digits scanned (1..8)
//     PRESCALE       clk cycles per digit (>= 2)
//     SEG_ACTIVE_LOW 1: lit segment = 0
//     DIG_ACTIVE_LOW 1: enabled digit = 0
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   seven_seg_scan_driver_if.slave (value_in, load, blank_in in;
//           segment, digit_sel, frame_tick, pending, dbg_idx out)
//
//   Build option
//     SEVSEG_LZ_BLANK_EN  when defined, digits above digit 0 whose nibble and
//                         all more-significant nibbles are zero are shown
//                         dark (digit enable still driven).
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  seven_seg_scan_driver_if.slave bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int VAL_W = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  // XOR masks that turn the active-high internal view into pin polarity;
  // they are also the "all off" pin values.
  localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACTIVE_LOW}};

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]    pre_cnt;
  logic [IDX_W-1:0]    idx;
  logic [VAL_W-1:0]    disp_reg;
  logic [VAL_W-1:0]    pend_reg;
  logic                pend_flag;
  logic [6:0]          seg_q;
  logic [N_DIGITS-1:0] dig_q;

  logic                pre_wrap;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic [N_DIGITS-1:0] cur_onehot;
  logic                lz_blank;
  logic [6:0]          seg_lit;
  logic [N_DIGITS-1:0] dig_en;

  assign pre_wrap = (pre_cnt == CNT_LAST);
  // The frame ends on the wrap of the last digit; with one digit every
  // prescaler wrap qualifies because idx is always IDX_LAST (= 0).
  assign boundary = pre_wrap && (idx == IDX_LAST);

  // Scan position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + CNT_W'(1);
      if (pre_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Value capture. A load on the boundary cycle bypasses pend_reg so the
  // newest value is what the next frame shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        disp_reg <= bus.value_in;
      end else if (pend_flag) begin
        disp_reg <= pend_reg;
      end
      pend_flag <= 1'b0;
    end else if (bus.load) begin
      pend_reg  <= bus.value_in;
      pend_flag <= 1'b1;
    end
  end

  // Select the nibble and digit enable for the current scan index.
  always_comb begin
    cur_nib    = '0;
    cur_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib       = disp_reg[4*k +: 4];
        cur_onehot[k] = 1'b1;
      end
    end
  end

`ifdef SEVSEG_LZ_BLANK_EN
  // Blank digit idx (> 0) when it and every more-significant nibble is 0.
  always_comb begin
    lz_blank = (idx != '0);
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((IDX_W'(j) >= idx) && (disp_reg[4*j +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_lit = glyph(cur_nib);
    dig_en  = cur_onehot;
    if (bus.blank_in) begin
      seg_lit = '0;
      dig_en  = '0;
    end else if (lz_blank) begin
      seg_lit = '0;
    end
  end

  // Pin registers: one cycle behind idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_lit ^ SEG_OFF;
      dig_q <= dig_en ^ DIG_OFF;
    end
  end

  assign bus.segment    = seg_q;
  assign bus.digit_sel  = dig_q;
  assign bus.frame_tick = boundary;
  assign bus.pending    = pend_flag;
  assign bus.dbg_idx    = 3'(idx);

endmodule
